axis_rr_arb_mux: RTL and testbench

- N-input AXI-Stream packet arbiter and multiplexer. It shares one downstream stream (for example a reg_axis slice or a DUT sink) between several masters.
- Round-robin grant at packet granularity: once an input is granted, it keeps the output until its tlast beat has been transferred.
- The output is a registered stage that sustains full throughput.
- Inputs use flattened vectors; the output maps directly onto an axis_if master.

---
 rtl/axis_rr_arb_mux.sv | 173 +++++++++++++++++
 tb/tb_axis_rr_arb_mux.sv | 468 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_rr_arb_mux.sv
// axis_rr_arb_mux
// N-input AXI-Stream packet arbiter and multiplexer. Inputs are granted
// round-robin, one whole packet at a time. The output is a registered stage
// that can forward one beat per cycle.
// Optional macro AXIS_RR_ARB_ID_EN adds the m_id port, which carries the
// source index of every beat.
//
// state | meaning
// IDLE  | no grant held; next request wins, searching from last_grant+1
// BUSY  | input r_grant owns the output until its tlast beat is loaded
module axis_rr_arb_mux #(
  parameter int NUM_INPUTS  = 4,
  parameter int DATA_WIDTH  = 32,
  parameter int USER_WIDTH  = 2,
  parameter int KEEP_WIDTH  = DATA_WIDTH / 8,
  localparam int ID_WIDTH   = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_INPUTS*DATA_WIDTH-1:0] s_data,
  input  logic [NUM_INPUTS*KEEP_WIDTH-1:0] s_keep,
  input  logic [NUM_INPUTS*USER_WIDTH-1:0] s_user,
  input  logic [NUM_INPUTS-1:0]            s_last,
  input  logic [NUM_INPUTS-1:0]            s_valid,
  output logic [NUM_INPUTS-1:0]            s_ready,
  output logic [DATA_WIDTH-1:0]            m_data,
  output logic [KEEP_WIDTH-1:0]            m_keep,
  output logic [USER_WIDTH-1:0]            m_user,
  output logic                             m_last,
  output logic                             m_valid,
  input  logic                             m_ready
`ifdef AXIS_RR_ARB_ID_EN
  ,
  output logic [ID_WIDTH-1:0]              m_id
`endif
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [ID_WIDTH-1:0]     r_grant;
  logic [ID_WIDTH-1:0]     w_grant_nxt;
  logic [ID_WIDTH-1:0]     r_last_grant;
  logic [ID_WIDTH-1:0]     w_last_grant_nxt;

  logic [NUM_INPUTS-1:0]   w_grant_onehot;
  logic [ID_WIDTH-1:0]     w_arb_ptr;
  logic [NUM_INPUTS-1:0]   w_arb_req;
  logic                    w_arb_found;
  logic [ID_WIDTH-1:0]     w_arb_pick;

  logic                    w_ready_grant;
  logic                    w_sel_valid;
  logic                    w_sel_last;
  logic [DATA_WIDTH-1:0]   w_sel_data;
  logic [KEEP_WIDTH-1:0]   w_sel_keep;
  logic [USER_WIDTH-1:0]   w_sel_user;
  logic                    w_load;

  assign w_grant_onehot = NUM_INPUTS'(1) << r_grant;

  // Select the granted slice of the flattened input vectors.
  always_comb begin
    w_sel_valid = s_valid[r_grant];
    w_sel_last  = s_last[r_grant];
    w_sel_data  = s_data[int'(r_grant)*DATA_WIDTH +: DATA_WIDTH];
    w_sel_keep  = s_keep[int'(r_grant)*KEEP_WIDTH +: KEEP_WIDTH];
    w_sel_user  = s_user[int'(r_grant)*USER_WIDTH +: USER_WIDTH];
  end

  // The output register can take a beat when it is empty or is being drained.
  assign w_ready_grant = (r_state == ST_BUSY) & (~m_valid | m_ready);
  assign w_load        = w_sel_valid & w_ready_grant;

  // Only the granted input ever sees ready.
  always_comb begin
    s_ready          = '0;
    s_ready[r_grant] = w_ready_grant;
  end

  // Round-robin search, starting one past the pointer and wrapping. While BUSY
  // the current owner is masked so it cannot win twice in a row.
  always_comb begin
    w_arb_ptr   = r_last_grant;
    w_arb_req   = s_valid;
    if (r_state == ST_BUSY) begin
      w_arb_ptr = r_grant;
      w_arb_req = s_valid & ~w_grant_onehot;
    end
    w_arb_found = 1'b0;
    w_arb_pick  = '0;
    for (int k = 1; k <= NUM_INPUTS; k++) begin
      if (!w_arb_found && w_arb_req[(int'(w_arb_ptr) + k) % NUM_INPUTS]) begin
        w_arb_found = 1'b1;
        w_arb_pick  = ID_WIDTH'((int'(w_arb_ptr) + k) % NUM_INPUTS);
      end
    end
  end

  // Next-state logic: grant on request, hand over right after the tlast load.
  always_comb begin
    w_state_nxt      = r_state;
    w_grant_nxt      = r_grant;
    w_last_grant_nxt = r_last_grant;
    unique case (r_state)
      ST_IDLE: begin
        if (w_arb_found) begin
          w_state_nxt = ST_BUSY;
          w_grant_nxt = w_arb_pick;
        end
      end
      ST_BUSY: begin
        if (w_load && w_sel_last) begin
          w_last_grant_nxt = r_grant;
          if (w_arb_found) begin
            w_grant_nxt = w_arb_pick;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State, grant and round-robin pointer registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= ST_IDLE;
      r_grant      <= '0;
      r_last_grant <= ID_WIDTH'(NUM_INPUTS - 1);
    end else begin
      r_state      <= w_state_nxt;
      r_grant      <= w_grant_nxt;
      r_last_grant <= w_last_grant_nxt;
    end
  end

  // Output stage: load on handshake, drain on m_ready, hold otherwise.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_valid <= 1'b0;
      m_data  <= '0;
      m_keep  <= '0;
      m_user  <= '0;
      m_last  <= 1'b0;
    end else if (w_load) begin
      m_valid <= 1'b1;
      m_data  <= w_sel_data;
      m_keep  <= w_sel_keep;
      m_user  <= w_sel_user;
      m_last  <= w_sel_last;
    end else if (m_ready) begin
      m_valid <= 1'b0;
    end
  end

`ifdef AXIS_RR_ARB_ID_EN
  // Source index travels with each beat through the output register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_id <= '0;
    end else if (w_load) begin
      m_id <= r_grant;
    end
  end
`endif

endmodule

// File: tb/tb_axis_rr_arb_mux.sv
// Bench for axis_rr_arb_mux: directed scenarios plus randomized traffic,
// checked against a packet-level round-robin model and per-source scoreboards.
module tb_axis_rr_arb_mux;
  localparam int N  = 4;
  localparam int DW = 32;
  localparam int UW = 2;
  localparam int KW = DW / 8;

  typedef struct packed {
    logic [DW-1:0] d;
    logic [KW-1:0] k;
    logic [UW-1:0] u;
    logic          l;
  } beat_t;

  typedef struct {
    int    cyc;
    beat_t b;
    int    id;
  } obs_t;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [N*DW-1:0] s_data = '0;
  logic [N*KW-1:0] s_keep = '0;
  logic [N*UW-1:0] s_user = '0;
  logic [N-1:0]    s_last = '0;
  logic [N-1:0]    s_valid = '0;
  logic [N-1:0]    s_ready;
  logic [DW-1:0]   m_data;
  logic [KW-1:0]   m_keep;
  logic [UW-1:0]   m_user;
  logic            m_last;
  logic            m_valid;
  logic            m_ready = 1'b0;
`ifdef AXIS_RR_ARB_ID_EN
  logic [1:0]      m_id;
`endif

  axis_rr_arb_mux #(
    .NUM_INPUTS(N),
    .DATA_WIDTH(DW),
    .USER_WIDTH(UW)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .s_data  (s_data),
    .s_keep  (s_keep),
    .s_user  (s_user),
    .s_last  (s_last),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .m_data  (m_data),
    .m_keep  (m_keep),
    .m_user  (m_user),
    .m_last  (m_last),
    .m_valid (m_valid),
    .m_ready (m_ready)
`ifdef AXIS_RR_ARB_ID_EN
    ,
    .m_id    (m_id)
`endif
  );

  always #5 clk = ~clk;

  int       compared = 0;
  int       mismatched = 0;
  beat_t    drv_q[N][$];
  beat_t    exp_q[N][$];
  int       exp_grants[$];
  obs_t     out_log[$];
  int       owner;
  int       last_g;
  int       out_src;
  int       cyc;
  int       first_mv_cyc;
  int       rise_cyc[N];
  int       gap_pct = 0;
  int       rdy_mode = 0;
  int       rdy_phase = 0;
  logic     prev_stall;
  beat_t    prev_beat;
  logic [N-1:0] pend_hs;

  // Round-robin rule: first requester after 'from', wrapping modulo N.
  function automatic int rr_pick(int from, logic [N-1:0] req);
    int r = -1;
    for (int k = 1; k <= N; k++) begin
      int idx = (from + k) % N;
      if (r < 0 && req[idx]) r = idx;
    end
    return r;
  endfunction

  function automatic beat_t mk(int src, int pkt, int bt, logic l);
    beat_t b;
    b.d = {8'(src), 8'(pkt), 8'(bt), 8'($urandom)};
    b.k = KW'($urandom_range(1, (1 << KW) - 1));
    b.u = UW'($urandom);
    b.l = l;
    return b;
  endfunction

  task automatic push_beat(int src, beat_t b);
    drv_q[src].push_back(b);
    exp_q[src].push_back(b);
  endtask

  task automatic push_pkt(int src, int pkt, int len);
    for (int b = 0; b < len; b++) push_beat(src, mk(src, pkt, b, b == len - 1));
  endtask

  // Sample phase, a few ns before the rising edge.
  task automatic sample();
    logic [N-1:0] v, r, expr;
    beat_t ob;
    obs_t  o;
    int    w;
    v = s_valid;
    r = s_ready;
    expr = '0;
    if (owner >= 0) expr[owner] = ~m_valid | m_ready;
    compared++;
    if (r !== expr) begin
      mismatched++;
      $display("FAIL s_ready cyc=%0d got=%b want=%b", cyc, r, expr);
    end
    ob = {m_data, m_keep, m_user, m_last};
    if (prev_stall) begin
      compared++;
      if (m_valid !== 1'b1 || ob !== prev_beat) begin
        mismatched++;
        $display("FAIL stall_hold cyc=%0d got=%h/%b want=%h/1", cyc, ob, m_valid, prev_beat);
      end
    end
    if (m_valid === 1'b1 && first_mv_cyc < 0) first_mv_cyc = cyc;
    if (m_valid === 1'b1 && m_ready === 1'b1) begin
      compared++;
      if (out_src < 0) begin
        if (exp_grants.size() == 0) begin
          mismatched++;
          $display("FAIL unexpected_packet cyc=%0d got=%h want=no_beat", cyc, ob);
        end else begin
          out_src = exp_grants.pop_front();
        end
      end
      if (out_src >= 0) begin
        if (exp_q[out_src].size() == 0) begin
          mismatched++;
          $display("FAIL extra_beat cyc=%0d src=%0d got=%h want=none", cyc, out_src, ob);
        end else begin
          beat_t eb = exp_q[out_src].pop_front();
          if (ob !== eb) begin
            mismatched++;
            $display("FAIL beat cyc=%0d src=%0d got=%h want=%h", cyc, out_src, ob, eb);
          end
        end
        if (m_last) out_src = -1;
      end
      o.cyc = cyc;
      o.b   = ob;
`ifdef AXIS_RR_ARB_ID_EN
      o.id  = int'(m_id);
`else
      o.id  = -1;
`endif
      out_log.push_back(o);
    end
    pend_hs = v & r;
    if (owner < 0) begin
      if (v != '0) begin
        owner = rr_pick(last_g, v);
        exp_grants.push_back(owner);
      end
    end else if (pend_hs[owner] && s_last[owner]) begin
      last_g = owner;
      w = rr_pick(owner, v & ~(N'(1) << owner));
      owner = w;
      if (w >= 0) exp_grants.push_back(w);
    end
    prev_stall = m_valid & ~m_ready;
    prev_beat  = ob;
  endtask

  // Drive phase, just after the rising edge.
  task automatic drive();
    logic vold;
    for (int i = 0; i < N; i++) begin
      if (pend_hs[i] && drv_q[i].size() > 0) void'(drv_q[i].pop_front());
    end
    for (int i = 0; i < N; i++) begin
      vold = s_valid[i];
      if (!(vold && !pend_hs[i])) begin
        if (drv_q[i].size() > 0 && $urandom_range(99) >= gap_pct) begin
          beat_t b = drv_q[i][0];
          if (!vold) rise_cyc[i] = cyc;
          s_valid[i] = 1'b1;
          s_data[i*DW +: DW] = b.d;
          s_keep[i*KW +: KW] = b.k;
          s_user[i*UW +: UW] = b.u;
          s_last[i] = b.l;
        end else begin
          s_valid[i] = 1'b0;
        end
      end
    end
    pend_hs = '0;
    case (rdy_mode)
      1:       begin m_ready = (rdy_phase % 3 == 0); rdy_phase++; end
      2:       m_ready = ($urandom_range(99) < 65);
      default: m_ready = 1'b1;
    endcase
  endtask

  task automatic step();
    sample();
    @(posedge clk);
    #1;
    cyc++;
    drive();
    #3;
  endtask

  function automatic logic busy();
    logic b = (m_valid === 1'b1) || (owner >= 0);
    for (int i = 0; i < N; i++) if (drv_q[i].size() > 0 || exp_q[i].size() > 0) b = 1'b1;
    return b;
  endfunction

  task automatic run_until_done(int max_cyc, string name);
    int n = 0;
    while (busy() && n < max_cyc) begin
      step();
      n++;
    end
    compared++;
    if (busy()) begin
      mismatched++;
      $display("FAIL %s_timeout got=%0d_cycles want=drained", name, n);
    end
    compared++;
    if (exp_grants.size() != 0) begin
      mismatched++;
      $display("FAIL %s_grants_left got=%0d want=0", name, exp_grants.size());
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    s_valid = '0; s_data = '0; s_keep = '0; s_user = '0; s_last = '0;
    m_ready = 1'b0;
    for (int i = 0; i < N; i++) begin
      drv_q[i].delete();
      exp_q[i].delete();
      rise_cyc[i] = -1;
    end
    exp_grants.delete();
    out_log.delete();
    owner = -1; last_g = N - 1; out_src = -1;
    cyc = 0; first_mv_cyc = -1; rdy_phase = 0;
    prev_stall = 1'b0; pend_hs = '0;
    repeat (2) @(posedge clk);
    #4;
    rst = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    compared++; if (m_valid !== 1'b0) begin mismatched++; $display("FAIL rst_m_valid got=%b want=0", m_valid); end
    compared++; if (m_data !== '0) begin mismatched++; $display("FAIL rst_m_data got=%h want=0", m_data); end
    compared++; if (m_keep !== '0) begin mismatched++; $display("FAIL rst_m_keep got=%h want=0", m_keep); end
    compared++; if (m_user !== '0) begin mismatched++; $display("FAIL rst_m_user got=%h want=0", m_user); end
    compared++; if (m_last !== 1'b0) begin mismatched++; $display("FAIL rst_m_last got=%b want=0", m_last); end
    compared++; if (s_ready !== '0) begin mismatched++; $display("FAIL rst_s_ready got=%b want=0", s_ready); end
`ifdef AXIS_RR_ARB_ID_EN
    compared++; if (m_id !== '0) begin mismatched++; $display("FAIL rst_m_id got=%0d want=0", m_id); end
`endif
  endtask

  task automatic test_single();
    logic [31:0] dv[3];
    beat_t b;
    dv[0] = 32'h11; dv[1] = 32'h22; dv[2] = 32'h33;
    do_reset();
    rdy_mode = 0; gap_pct = 0;
    for (int j = 0; j < 3; j++) begin
      b.d = dv[j]; b.k = 4'hF; b.u = UW'(j); b.l = (j == 2);
      push_beat(2, b);
    end
    run_until_done(50, "single");
    compared++;
    if (first_mv_cyc - rise_cyc[2] != 2) begin
      mismatched++;
      $display("FAIL single_latency got=%0d want=2", first_mv_cyc - rise_cyc[2]);
    end
    compared++;
    if (out_log.size() != 3) begin
      mismatched++;
      $display("FAIL single_count got=%0d want=3", out_log.size());
    end else begin
      for (int j = 0; j < 3; j++) begin
        compared++;
        if (out_log[j].b.d !== dv[j] || out_log[j].b.l !== (j == 2) ||
            (j > 0 && out_log[j].cyc != out_log[j-1].cyc + 1)) begin
          mismatched++;
          $display("FAIL single_beat%0d got=%h/%b@%0d want=%h/%b", j, out_log[j].b.d,
                   out_log[j].b.l, out_log[j].cyc, dv[j], j == 2);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    rdy_mode = 0; gap_pct = 0;
    for (int p = 0; p < 2; p++) for (int s = 0; s < N; s++) push_pkt(s, p, 2);
    run_until_done(100, "b2b");
    compared++;
    if (out_log.size() != 16) begin
      mismatched++;
      $display("FAIL b2b_count got=%0d want=16", out_log.size());
    end else begin
      for (int j = 0; j < 16; j++) begin
        int src = (j / 2) % N;
        compared++;
        if (out_log[j].b.d[31:24] !== 8'(src) || out_log[j].b.l !== (j % 2 == 1)) begin
          mismatched++;
          $display("FAIL b2b_order beat=%0d got=src%0d/last%b want=src%0d/last%b", j,
                   out_log[j].b.d[31:24], out_log[j].b.l, src, j % 2 == 1);
        end
        if (j > 0) begin
          compared++;
          if (out_log[j].cyc != out_log[j-1].cyc + 1) begin
            mismatched++;
            $display("FAIL b2b_bubble beat=%0d got=cyc%0d want=cyc%0d", j, out_log[j].cyc,
                     out_log[j-1].cyc + 1);
          end
        end
`ifdef AXIS_RR_ARB_ID_EN
        compared++;
        if (out_log[j].id != src) begin
          mismatched++;
          $display("FAIL b2b_m_id beat=%0d got=%0d want=%0d", j, out_log[j].id, src);
        end
`endif
      end
    end
  endtask

  task automatic test_backpressure();
    beat_t sent[$];
    do_reset();
    rdy_mode = 1; gap_pct = 0;
    push_pkt(1, 7, 4);
    foreach (exp_q[1][j]) sent.push_back(exp_q[1][j]);
    run_until_done(100, "bp");
    compared++;
    if (out_log.size() != 4) begin
      mismatched++;
      $display("FAIL bp_count got=%0d want=4", out_log.size());
    end else begin
      for (int j = 0; j < 4; j++) begin
        compared++;
        if (out_log[j].b !== sent[j]) begin
          mismatched++;
          $display("FAIL bp_beat%0d got=%h want=%h", j, out_log[j].b, sent[j]);
        end
      end
    end
    rdy_mode = 0;
  endtask

  task automatic test_mid_packet();
    do_reset();
    rdy_mode = 0; gap_pct = 0;
    push_pkt(0, 1, 5);
    repeat (4) step();
    push_pkt(3, 2, 2);
    run_until_done(100, "mid");
    compared++;
    if (out_log.size() != 7) begin
      mismatched++;
      $display("FAIL mid_count got=%0d want=7", out_log.size());
    end else begin
      for (int j = 0; j < 7; j++) begin
        int src = (j < 5) ? 0 : 3;
        compared++;
        if (out_log[j].b.d[31:24] !== 8'(src)) begin
          mismatched++;
          $display("FAIL mid_order beat=%0d got=src%0d want=src%0d", j, out_log[j].b.d[31:24], src);
        end
      end
      compared++;
      if (out_log[5].cyc != out_log[4].cyc + 1) begin
        mismatched++;
        $display("FAIL mid_bubble got=cyc%0d want=cyc%0d", out_log[5].cyc, out_log[4].cyc + 1);
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    rdy_mode = 0; gap_pct = 0;
    push_pkt(2, 3, 4);
    repeat (4) step();
    rst = 1'b0;
    #1;
    compared++; if (m_valid !== 1'b0) begin mismatched++; $display("FAIL midrst_m_valid got=%b want=0", m_valid); end
    compared++; if (s_ready !== '0) begin mismatched++; $display("FAIL midrst_s_ready got=%b want=0", s_ready); end
    compared++; if (m_data !== '0) begin mismatched++; $display("FAIL midrst_m_data got=%h want=0", m_data); end
    do_reset();
    push_pkt(3, 4, 2);
    push_pkt(1, 5, 2);
    run_until_done(100, "midrst");
    compared++;
    if (out_log.size() != 4) begin
      mismatched++;
      $display("FAIL midrst_count got=%0d want=4", out_log.size());
    end else begin
      compared++;
      if (out_log[0].b.d[31:24] !== 8'd1 || out_log[2].b.d[31:24] !== 8'd3) begin
        mismatched++;
        $display("FAIL midrst_first_grant got=src%0d,src%0d want=src1,src3",
                 out_log[0].b.d[31:24], out_log[2].b.d[31:24]);
      end
    end
  endtask

  task automatic test_random();
    int total = 0;
    int pkt = 0;
    do_reset();
    rdy_mode = 2; gap_pct = 30;
    for (int round = 0; round < 5; round++) begin
      for (int s = 0; s < N; s++) begin
        int np = $urandom_range(0, 2);
        for (int p = 0; p < np; p++) begin
          int len = $urandom_range(1, 5);
          push_pkt(s, pkt, len);
          pkt++;
          total += len;
        end
      end
      repeat (25) step();
    end
    run_until_done(3000, "rand");
    compared++;
    if (out_log.size() != total) begin
      mismatched++;
      $display("FAIL rand_count got=%0d want=%0d", out_log.size(), total);
    end
    rdy_mode = 0; gap_pct = 0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_mid_packet();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
